apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB initiator that turns single-beat commands from a local controller (test sequencer, CPU shim) into APB SETUP/ACCESS transfers toward the GPIO register slave.
- It is the other end of the GPIO APB slave: it drives the paddr, psel, penable, pwrite and pwdata signals that the slave decodes into its register write enable, address and write data.
- It returns read data or error on a response channel, with backpressure, and aborts any transfer whose pready stays low for too long.

Parameters:
- ADDR_W, 32, width of the command address and paddr.
- DATA_W, 32, width of the write data, read data and APB data buses.
- TIMEOUT, 16, maximum number of ACCESS cycles to wait for pready before aborting; legal range is 2 to 255.

Ports:
sysclk  in  1  single clock for all logic.
sysrst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command can be accepted this cycle.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W  target byte address.
cmd_wdata  in  DATA_W  write data.
rsp_valid  out  1  response held until it is consumed.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
rsp_err  out  1  pslverr seen, or timeout.
rsp_timeout  out  1  transfer aborted by timeout.
paddr  out  ADDR_W  APB address.
psel  out  1  APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction.
pwdata  out  DATA_W  APB write data.
prdata  in  DATA_W  APB read data.
pready  in  1  APB ready.
pslverr  in  1  APB slave error.

Behaviour:
- Reset, sampled on the sysclk rising edge while sysrst=1:
  - state goes to IDLE; psel, penable, pwrite = 0; paddr, pwdata = 0.
  - rsp_valid, rsp_err, rsp_timeout = 0; rsp_rdata = 0; timeout counter = 0.
  - Reset mid-transfer drops psel/penable at that same edge; the outstanding response is discarded.
- State machine, 3 states, all APB outputs registered:
  - IDLE: cmd_ready = (state==IDLE) && !rsp_valid.
    - On cmd_valid && cmd_ready, latch addr, wdata and write into paddr, pwdata and pwrite.
    - Go to SETUP.
  - SETUP: psel=1, penable=0; lasts exactly 1 cycle; then go to ACCESS with counter cleared.
  - ACCESS: psel=1, penable=1.
    - If pready=1: capture rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, rsp_timeout = 0.
    - Set rsp_valid=1, drop psel/penable, return to IDLE.
    - Else increment the counter.
    - When the counter reaches TIMEOUT-1 with pready still 0: rsp_err=1, rsp_timeout=1, rsp_rdata=0, rsp_valid=1, drop psel/penable, return to IDLE.
- Latency with a zero-wait slave:
  - Command accepted at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid from cycle N+3.
  - The minimum issue interval is therefore 3 cycles plus the response-consumption cycle.
- Response channel:
  - rsp_valid stays high and the rsp_* fields stay stable until rsp_valid && rsp_ready.
  - It clears on that edge; cmd_ready rises in the next cycle.
  - There is no bypass: a command can never be accepted in the same cycle a response is consumed.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS, and hold their last value while in IDLE.
- pwdata holds the latched cmd_wdata even on reads (don't-care to the slave).
- A timeout counts as an aborted transfer. A pready that arrives late, after the abort, is ignored because psel=0.
- No address checking: unaligned or unmapped addresses are forwarded unchanged. The slave's x/0 read of an unmapped address is passed through as-is.
- Back-to-back commands while a response is pending are stalled by cmd_ready=0; commands are never dropped.

Decomposition:
- Shared package/definitions file holds:
  - the state encoding APB_IDLE=2'd0, APB_SETUP=2'd1, APB_ACCESS=2'd2;
  - the default TIMEOUT constant;
  - the existing GPIO register offsets, which the bench reuses for stimulus.
- One natural sub-module: apb_timeout_counter, holding the counter with clear, enable, count and expired; it is instantiated once.

Test Plan:
- Zero-wait write to addr 0x04, data 0x0000_00FF, pready tied high:
  - psel rises 1 cycle after acceptance; penable follows 1 cycle later with pwrite=1 and pwdata=0xFF.
  - rsp_valid appears at N+3 with rsp_err=0 and rsp_rdata=0.
- Read of addr 0x00, slave holds pready low 3 cycles then returns prdata=0xA5A5_0001:
  - ACCESS lasts 4 cycles.
  - rsp_rdata=0xA5A5_0001, rsp_err=0.
- pslverr=1 with pready on a write:
  - rsp_err=1, rsp_timeout=0; psel drops the following cycle.
- pready stuck low, TIMEOUT=16:
  - exactly 16 ACCESS cycles occur.
  - Then rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A later pready pulse produces no second response.
- Response backpressure: hold rsp_ready=0 for 5 cycles while cmd_valid=1:
  - cmd_ready stays 0 and rsp fields stay stable.
  - After the handshake, the next command is accepted one cycle later.
- Assert sysrst during ACCESS:
  - at the next edge psel=0, penable=0, rsp_valid=0, state=IDLE.
  - cmd_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB master bridge: FSM encoding, timeout default and
// the GPIO slave register map used when driving commands at it.
package apb_master_bridge_pkg;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t APB_IDLE   = 2'd0;
    localparam apb_state_t APB_SETUP  = 2'd1;
    localparam apb_state_t APB_ACCESS = 2'd2;

    localparam int unsigned APB_TIMEOUT_DEFAULT = 16;

    // Counter is sized for the largest legal TIMEOUT (255).
    localparam int unsigned APB_TIMEOUT_CNT_W = 8;

    localparam logic [31:0] GPIO_DATA_OUT_OFS = 32'h0000_0000;
    localparam logic [31:0] GPIO_DIR_OFS      = 32'h0000_0004;
    localparam logic [31:0] GPIO_DATA_IN_OFS  = 32'h0000_0008;
    localparam logic [31:0] GPIO_IRQ_EN_OFS   = 32'h0000_000C;

endpackage

// File: rtl/apb_master_bridge_timeout.sv
// ACCESS-phase wait counter: cleared outside ACCESS, counts wait cycles, flags the
// last cycle that may still be waited before the transfer is aborted.
module apb_timeout_counter
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned WIDTH = APB_TIMEOUT_CNT_W,
    parameter int unsigned LIMIT = APB_TIMEOUT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [WIDTH-1:0] r_count;

    // Expired during the LIMIT-th wait cycle, so exactly LIMIT ACCESS cycles occur.
    assign o_expired = (r_count == WIDTH'(LIMIT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-beat command to APB SETUP/ACCESS initiator with a held response channel
// and a pready timeout that aborts stalled transfers.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = APB_TIMEOUT_DEFAULT
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_rsp_timeout,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_psel,
    output logic              o_penable,
    output logic              o_pwrite,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready,
    input  logic              i_pslverr
);

    apb_state_t        r_state;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_pwrite;
    logic              r_psel;
    logic              r_penable;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    logic w_cmd_ready;
    logic w_cmd_fire;
    logic w_in_access;
    logic w_expired;

    // No bypass: a pending response blocks new commands until it is consumed.
    assign w_cmd_ready = (r_state == APB_IDLE) && !r_rsp_valid;
    assign w_cmd_fire  = w_cmd_ready && i_cmd_valid;
    assign w_in_access = (r_state == APB_ACCESS);

    apb_timeout_counter #(
        .WIDTH (APB_TIMEOUT_CNT_W),
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_sysclk),
        .i_rst     (i_sysrst),
        .i_clear   (!w_in_access),
        .i_enable  (w_in_access && !i_pready),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_state       <= APB_IDLE;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pwrite      <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (r_rsp_valid && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end

            case (r_state)
                APB_IDLE: begin
                    if (w_cmd_fire) begin
                        r_paddr  <= i_cmd_addr;
                        r_pwdata <= i_cmd_wdata;
                        r_pwrite <= i_cmd_write;
                        r_psel   <= 1'b1;
                        r_state  <= APB_SETUP;
                    end
                end
                APB_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    if (i_pready) begin
                        r_rsp_rdata   <= r_pwrite ? '0 : i_prdata;
                        r_rsp_err     <= i_pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= APB_IDLE;
                    end else if (w_expired) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= APB_IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= APB_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready   = w_cmd_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_paddr       = r_paddr;
    assign o_psel        = r_psel;
    assign o_penable     = r_penable;
    assign o_pwrite      = r_pwrite;
    assign o_pwdata      = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: zero-wait, wait-state, slave error,
// timeout, response backpressure and mid-transfer reset.
module tb_apb_master_bridge;
    import apb_master_bridge_pkg::*;

    logic        sysclk;
    logic        sysrst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp = 0;
    int n_err = 0;

    apb_master_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .i_sysclk      (sysclk),
        .i_sysrst      (sysrst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_write   (cmd_write),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_wdata   (cmd_wdata),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_rsp_timeout (rsp_timeout),
        .o_paddr       (paddr),
        .o_psel        (psel),
        .o_penable     (penable),
        .o_pwrite      (pwrite),
        .o_pwdata      (pwdata),
        .i_prdata      (prdata),
        .i_pready      (pready),
        .i_pslverr     (pslverr)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge; caller must have checked cmd_ready.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    int          n_acc;
    logic [31:0] held_rdata;

    initial begin
        sysrst    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        step();
        step();
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        sysrst = 1'b0;
        step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);

        // Zero-wait write
        pready = 1'b1;
        issue(1'b1, GPIO_DIR_OFS, 32'h0000_00FF);
        chk("zw_setup_psel", 32'(psel), 32'd1);
        chk("zw_setup_penable", 32'(penable), 32'd0);
        chk("zw_setup_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("zw_paddr", paddr, 32'h4);
        step();
        chk("zw_access_penable", 32'(penable), 32'd1);
        chk("zw_access_pwrite", 32'(pwrite), 32'd1);
        chk("zw_access_pwdata", pwdata, 32'hFF);
        chk("zw_access_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("zw_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("zw_rsp_err", 32'(rsp_err), 32'd0);
        chk("zw_rsp_rdata", rsp_rdata, 32'd0);
        chk("zw_psel_drop", 32'(psel), 32'd0);
        consume();
        chk("zw_rsp_cleared", 32'(rsp_valid), 32'd0);
        chk("zw_cmd_ready_back", 32'(cmd_ready), 32'd1);

        // Read with 3 wait states
        pready = 1'b0;
        prdata = 32'hA5A5_0001;
        issue(1'b0, GPIO_DATA_OUT_OFS, 32'h1111_2222);
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (penable && psel) n_acc++;
            if (i == 3) pready = 1'b1;
        end
        chk("ws_access_cycles", 32'(n_acc), 32'd4);
        chk("ws_pwdata_on_read", pwdata, 32'h1111_2222);
        step();
        pready = 1'b0;
        chk("ws_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ws_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
        chk("ws_rsp_err", 32'(rsp_err), 32'd0);
        consume();

        // Slave error on a write
        pready  = 1'b1;
        pslverr = 1'b1;
        issue(1'b1, GPIO_DATA_OUT_OFS, 32'h0000_005A);
        step();
        chk("se_access_psel", 32'(psel), 32'd1);
        step();
        pslverr = 1'b0;
        chk("se_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("se_rsp_err", 32'(rsp_err), 32'd1);
        chk("se_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("se_psel_drop", 32'(psel), 32'd0);
        consume();

        // Timeout with pready stuck low
        pready = 1'b0;
        issue(1'b0, GPIO_DATA_IN_OFS, 32'h0);
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rsp_valid) break;
            if (penable && psel) n_acc++;
        end
        chk("to_access_cycles", 32'(n_acc), 32'd16);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        chk("to_psel_drop", 32'(psel), 32'd0);
        consume();
        pready = 1'b1;
        step();
        pready = 1'b0;
        step();
        chk("to_late_pready_no_rsp", 32'(rsp_valid), 32'd0);
        chk("to_late_pready_psel", 32'(psel), 32'd0);

        // Response backpressure with a command waiting
        pready = 1'b1;
        prdata = 32'h0BAD_F00D;
        issue(1'b0, GPIO_IRQ_EN_OFS, 32'h0);
        step();
        step();
        held_rdata = 32'h0BAD_F00D;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = GPIO_DATA_OUT_OFS + 32'h10;
        cmd_wdata = 32'h0000_1234;
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, held_rdata);
            chk("bp_rsp_err", 32'(rsp_err), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        chk("bp_no_bypass", 32'(cmd_ready), 32'd0);
        step();
        rsp_ready = 1'b0;
        chk("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
        chk("bp_cmd_ready_next", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("bp_accept_psel", 32'(psel), 32'd1);
        chk("bp_accept_paddr", paddr, 32'h10);
        chk("bp_accept_pwdata", pwdata, 32'h1234);
        step();
        step();
        chk("bp_second_rsp", 32'(rsp_valid), 32'd1);
        consume();

        // Reset during ACCESS
        pready = 1'b0;
        issue(1'b0, GPIO_DATA_OUT_OFS, 32'h0);
        step();
        chk("rs_in_access", 32'(penable), 32'd1);
        sysrst = 1'b1;
        step();
        chk("rs_psel", 32'(psel), 32'd0);
        chk("rs_penable", 32'(penable), 32'd0);
        chk("rs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rs_idle", 32'(cmd_ready), 32'd1);
        sysrst = 1'b0;
        pready = 1'b1;
        step();
        chk("rs_cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("rs_no_rsp_after", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
